// File: rtl/sp_ram_arbiter.sv
// Round-robin / fixed-priority arbiter sharing one single-port data RAM
// between two req/gnt/rvalid requesters, with window decode and error replies.
//
// Ports:
//   clock, reset          : single clock, synchronous active-high reset
//   req_i, we_i, be_i,
//   addr_i, wdata_i       : per-port request and payload (index 0/1)
//   gnt_o                 : per-port grant, combinational in the request cycle
//   rvalid_o, err_o,
//   rdata_o               : per-port response, one cycle after the grant
//   mem_*_o, mem_rdata_i  : RAM side; read data arrives one cycle after mem_en_o
module sp_ram_arbiter #(
    parameter int unsigned            ADDR_WIDTH     = 32,
    parameter int unsigned            DATA_WIDTH     = 32,
    parameter int unsigned            RAM_ADDR_WIDTH = 12,
    parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR      = 32'h0010_0000,
    parameter bit                     FIXED_PRIORITY = 1'b0
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic [1:0]                           req_i,
    input  logic [1:0]                           we_i,
    input  logic [1:0][DATA_WIDTH/8-1:0]         be_i,
    input  logic [1:0][ADDR_WIDTH-1:0]           addr_i,
    input  logic [1:0][DATA_WIDTH-1:0]           wdata_i,
    output logic [1:0]                           gnt_o,
    output logic [1:0]                           rvalid_o,
    output logic [1:0]                           err_o,
    output logic [1:0][DATA_WIDTH-1:0]           rdata_o,
    output logic                                 mem_en_o,
    output logic                                 mem_we_o,
    output logic [DATA_WIDTH/8-1:0]              mem_be_o,
    output logic [RAM_ADDR_WIDTH-1:0]            mem_addr_o,
    output logic [DATA_WIDTH-1:0]                mem_wdata_o,
    input  logic [DATA_WIDTH-1:0]                mem_rdata_i
);

    localparam int unsigned TAG_LSB = RAM_ADDR_WIDTH + 2;

    logic any_req;
    logic win;
    logic in_win;
    logic last_q;

    logic resp_valid_q;
    logic resp_port_q;
    logic resp_err_q;
    logic resp_we_q;

    // Byte-offset bits never reach the word-addressed RAM.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{addr_i[0][1:0], addr_i[1][1:0]};

    // Winner select; with no request the winner defaults to port 0 so the
    // don't-care RAM address/data are driven from port 0.
    always_comb begin
        any_req = (|req_i) & ~reset;
        win     = 1'b0;
        if (req_i == 2'b10) begin
            win = 1'b1;
        end else if (req_i == 2'b11) begin
            win = FIXED_PRIORITY ? 1'b0 : ~last_q;
        end
    end

    assign gnt_o  = any_req ? (win ? 2'b10 : 2'b01) : 2'b00;

    assign in_win = addr_i[win][ADDR_WIDTH-1:TAG_LSB]
                    == BASE_ADDR[ADDR_WIDTH-1:TAG_LSB];

    assign mem_en_o    = any_req & in_win;
    assign mem_we_o    = mem_en_o & we_i[win];
    assign mem_be_o    = mem_en_o ? be_i[win] : '0;
    assign mem_addr_o  = addr_i[win][RAM_ADDR_WIDTH+1:2];
    assign mem_wdata_o = wdata_i[win];

    always_ff @(posedge clock) begin
        if (reset) begin
            last_q       <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_port_q  <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_we_q    <= 1'b0;
        end else begin
            resp_valid_q <= any_req;
            resp_port_q  <= win;
            resp_err_q   <= ~in_win;
            resp_we_q    <= we_i[win];
            if (any_req) begin
                last_q <= win;
            end
        end
    end

    // A response registered just before reset rose is suppressed while
    // reset is held, so it is dropped rather than delivered late.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rvalid_o[p] = resp_valid_q & ~reset & (resp_port_q == 1'(p));
            err_o[p]    = rvalid_o[p] & resp_err_q;
            rdata_o[p]  = (rvalid_o[p] & ~resp_err_q & ~resp_we_q)
                          ? mem_rdata_i : '0;
        end
    end

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// Self-checking bench for sp_ram_arbiter: directed scenarios plus randomized
// traffic against a transaction-level model (winner rule, word memory).
module tb_sp_ram_arbiter;

    localparam logic [31:0] BASE = 32'h0010_0000;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic [1:0]        req = '0;
    logic [1:0]        we = '0;
    logic [1:0][3:0]   be = '0;
    logic [1:0][31:0]  addr = '0;
    logic [1:0][31:0]  wdata = '0;

    logic [1:0]        gnt, rvalid, err;
    logic [1:0][31:0]  rdata;
    logic              mem_en, mem_we;
    logic [3:0]        mem_be;
    logic [11:0]       mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    logic [1:0]        f_gnt, f_rvalid, f_err;
    logic [1:0][31:0]  f_rdata;
    logic              f_mem_en, f_mem_we;
    logic [3:0]        f_mem_be;
    logic [11:0]       f_mem_addr;
    logic [31:0]       f_mem_wdata;

    int n_checks = 0;
    int n_fail = 0;

    initial forever #5 clock = ~clock;

    sp_ram_arbiter dut (
        .clock(clock), .reset(reset), .req_i(req), .we_i(we), .be_i(be),
        .addr_i(addr), .wdata_i(wdata), .gnt_o(gnt), .rvalid_o(rvalid),
        .err_o(err), .rdata_o(rdata), .mem_en_o(mem_en), .mem_we_o(mem_we),
        .mem_be_o(mem_be), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata)
    );

    sp_ram_arbiter #(.FIXED_PRIORITY(1'b1)) dut_fp (
        .clock(clock), .reset(reset), .req_i(req), .we_i(we), .be_i(be),
        .addr_i(addr), .wdata_i(wdata), .gnt_o(f_gnt), .rvalid_o(f_rvalid),
        .err_o(f_err), .rdata_o(f_rdata), .mem_en_o(f_mem_en),
        .mem_we_o(f_mem_we), .mem_be_o(f_mem_be), .mem_addr_o(f_mem_addr),
        .mem_wdata_o(f_mem_wdata), .mem_rdata_i(32'h0)
    );

    // RAM environment (stands in for sp_ram_wrap)
    logic [31:0] ram [0:4095];
    always @(posedge clock) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end else begin
                mem_rdata <= ram[mem_addr];
            end
        end
    end

    // ---------------- reference model ----------------
    int          m_last = 1;
    logic [31:0] mdl [int];
    bit          pv = 0;
    int          pp = 0;
    bit          pe = 0;
    logic [31:0] pd = '0;
    int          e_win;
    logic [1:0]  e_gnt;
    bit          e_in;

    function automatic bit in_win(input logic [31:0] a);
        return (a >> 14) == (BASE >> 14);
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a - BASE) >> 2);
    endfunction

    function automatic void predict();
        e_win = -1;
        if (!reset) begin
            if (req == 2'b01) e_win = 0;
            else if (req == 2'b10) e_win = 1;
            else if (req == 2'b11) e_win = 1 - m_last;
        end
        e_gnt = (e_win == 0) ? 2'b01 : (e_win == 1) ? 2'b10 : 2'b00;
        e_in  = (e_win >= 0) && in_win(addr[e_win]);
    endfunction

    function automatic logic [1:0] x_rvalid();
        return pv ? ((pp == 0) ? 2'b01 : 2'b10) : 2'b00;
    endfunction

    function automatic logic [1:0] x_err();
        return pe ? x_rvalid() : 2'b00;
    endfunction

    function automatic logic [31:0] x_rdata(input int p);
        return (pv && pp == p) ? pd : 32'h0;
    endfunction

    task automatic advance();
        logic [31:0] w;
        int k;
        predict();
        @(posedge clock);
        if (reset) begin
            m_last = 1;
            pv = 0;
        end else if (e_win >= 0) begin
            m_last = e_win;
            pv = 1;
            pp = e_win;
            pe = !e_in;
            pd = '0;
            if (e_in) begin
                k = widx(addr[e_win]);
                w = mdl.exists(k) ? mdl[k] : 32'h0;
                if (we[e_win]) begin
                    for (int b = 0; b < 4; b++)
                        if (be[e_win][b]) w[8*b +: 8] = wdata[e_win][8*b +: 8];
                    mdl[k] = w;
                end else begin
                    pd = w;
                end
            end
        end else begin
            pv = 0;
        end
        #1;
    endtask

    task automatic set_port(input int p, input bit r, input bit w,
                            input logic [3:0] b, input logic [31:0] a,
                            input logic [31:0] d);
        req[p] = r; we[p] = w; be[p] = b; addr[p] = a; wdata[p] = d;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1;
        advance();
        set_port(0, 1, 0, 4'hF, BASE, 0);
        set_port(1, 1, 1, 4'hF, BASE + 4, 32'h1234);
        #1;
        n_checks++;
        if ({gnt, mem_en, mem_we, mem_be} !== 8'h0) begin
            n_fail++;
            $display("FAIL reset_req_side got=%h exp=0", {gnt, mem_en, mem_we, mem_be});
        end
        n_checks++;
        if ({rvalid, err, rdata} !== 68'h0) begin
            n_fail++;
            $display("FAIL reset_resp_side got=%h exp=0", {rvalid, err, rdata});
        end
        advance();
        req = 2'b00;
        reset = 0;
        advance();
    endtask

    task automatic test_single_read();
        set_port(0, 1, 1, 4'hF, 32'h0010_0010, 32'hDEAD_BEEF);
        #1;
        n_checks++;
        if ({gnt, mem_en, mem_we, mem_addr} !== {2'b01, 1'b1, 1'b1, 12'd4}) begin
            n_fail++;
            $display("FAIL wr_grant got=%h exp=%h", {gnt, mem_en, mem_we, mem_addr},
                     {2'b01, 1'b1, 1'b1, 12'd4});
        end
        advance();
        set_port(0, 1, 0, 4'hF, 32'h0010_0010, 32'h0);
        #1;
        n_checks++;
        if ({rvalid, err, rdata[0]} !== {2'b01, 2'b00, 32'h0}) begin
            n_fail++;
            $display("FAIL wr_resp got=%h exp=%h", {rvalid, err, rdata[0]},
                     {2'b01, 2'b00, 32'h0});
        end
        n_checks++;
        if ({gnt, mem_en, mem_we, mem_addr} !== {2'b01, 1'b1, 1'b0, 12'd4}) begin
            n_fail++;
            $display("FAIL rd_grant got=%h exp=%h", {gnt, mem_en, mem_we, mem_addr},
                     {2'b01, 1'b1, 1'b0, 12'd4});
        end
        advance();
        req = 2'b00;
        #1;
        n_checks++;
        if ({rvalid, err, rdata[0], rdata[1]} !== {2'b01, 2'b00, 32'hDEAD_BEEF, 32'h0}) begin
            n_fail++;
            $display("FAIL rd_resp got=%h exp=%h", {rvalid, err, rdata[0], rdata[1]},
                     {2'b01, 2'b00, 32'hDEAD_BEEF, 32'h0});
        end
        advance();
    endtask

    task automatic test_byte_enables();
        set_port(1, 1, 1, 4'hF, 32'h0010_0020, 32'hFFFF_FFFF);
        advance();
        set_port(1, 1, 1, 4'b0110, 32'h0010_0020, 32'h1122_3344);
        #1;
        n_checks++;
        if ({gnt, mem_be} !== {2'b10, 4'b0110}) begin
            n_fail++;
            $display("FAIL be_grant got=%h exp=%h", {gnt, mem_be}, {2'b10, 4'b0110});
        end
        advance();
        set_port(1, 1, 0, 4'hF, 32'h0010_0020, 32'h0);
        advance();
        req = 2'b00;
        #1;
        n_checks++;
        if ({rvalid, rdata[1], rdata[0]} !== {2'b10, 32'hFF22_33FF, 32'h0}) begin
            n_fail++;
            $display("FAIL be_read got=%h exp=%h", {rvalid, rdata[1], rdata[0]},
                     {2'b10, 32'hFF22_33FF, 32'h0});
        end
        advance();
    endtask

    task automatic test_out_of_window();
        set_port(0, 1, 0, 4'hF, 32'h0020_0000, 32'h0);
        #1;
        n_checks++;
        if ({gnt[0], mem_en, mem_we, mem_be} !== {1'b1, 1'b0, 1'b0, 4'h0}) begin
            n_fail++;
            $display("FAIL oow_grant got=%h exp=%h", {gnt[0], mem_en, mem_we, mem_be},
                     {1'b1, 1'b0, 1'b0, 4'h0});
        end
        advance();
        req = 2'b00;
        #1;
        n_checks++;
        if ({rvalid[0], err[0], rdata[0]} !== {1'b1, 1'b1, 32'h0}) begin
            n_fail++;
            $display("FAIL oow_resp got=%h exp=%h", {rvalid[0], err[0], rdata[0]},
                     {1'b1, 1'b1, 32'h0});
        end
        advance();
    endtask

    task automatic test_contention();
        logic [1:0]  order [6];
        logic [31:0] val [2];
        val[0] = 32'hDEAD_BEEF;
        val[1] = 32'hFF22_33FF;
        for (int i = 0; i < 6; i++) order[i] = (i % 2 == 0) ? 2'b01 : 2'b10;
        reset = 1;
        req = 2'b00;
        advance();
        reset = 0;
        set_port(0, 1, 0, 4'hF, 32'h0010_0010, 32'h0);
        set_port(1, 1, 0, 4'hF, 32'h0010_0020, 32'h0);
        for (int i = 0; i < 6; i++) begin
            #1;
            n_checks++;
            if (gnt !== order[i]) begin
                n_fail++;
                $display("FAIL cont_gnt[%0d] got=%b exp=%b", i, gnt, order[i]);
            end
            advance();
            if (i == 5) req = 2'b00;
            #1;
            n_checks++;
            if ({rvalid, rdata[i%2], rdata[1-(i%2)]} !== {order[i], val[i%2], 32'h0}) begin
                n_fail++;
                $display("FAIL cont_resp[%0d] got=%h exp=%h", i,
                         {rvalid, rdata[i%2], rdata[1-(i%2)]}, {order[i], val[i%2], 32'h0});
            end
            #(-0);
        end
        advance();
    endtask

    task automatic test_fixed_priority();
        set_port(0, 1, 0, 4'hF, 32'h0010_0010, 32'h0);
        set_port(1, 1, 0, 4'hF, 32'h0010_0020, 32'h0);
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++;
            if (f_gnt !== 2'b01) begin
                n_fail++;
                $display("FAIL fp_gnt[%0d] got=%b exp=01", i, f_gnt);
            end
            advance();
        end
        req[0] = 1'b0;
        #1;
        n_checks++;
        if (f_gnt !== 2'b10) begin
            n_fail++;
            $display("FAIL fp_drop got=%b exp=10", f_gnt);
        end
        advance();
        req = 2'b00;
        advance();
    endtask

    task automatic test_reset_mid();
        set_port(1, 1, 0, 4'hF, 32'h0010_0020, 32'h0);
        #1;
        n_checks++;
        if (gnt !== 2'b10) begin
            n_fail++;
            $display("FAIL rmid_gnt got=%b exp=10", gnt);
        end
        advance();
        reset = 1;
        req = 2'b11;
        #1;
        n_checks++;
        if ({rvalid, err, gnt} !== 6'h0) begin
            n_fail++;
            $display("FAIL rmid_drop got=%h exp=0", {rvalid, err, gnt});
        end
        advance();
        reset = 0;
        #1;
        n_checks++;
        if ({rvalid, gnt} !== {2'b00, 2'b01}) begin
            n_fail++;
            $display("FAIL rmid_tie got=%b exp=%b", {rvalid, gnt}, 4'b0001);
        end
        advance();
        req = 2'b00;
        #1;
        n_checks++;
        if (rvalid !== 2'b01) begin
            n_fail++;
            $display("FAIL rmid_resp got=%b exp=01", rvalid);
        end
        advance();
    endtask

    task automatic test_random();
        int idx;
        int prev_win;
        for (int i = 0; i < 4; i++) begin
            set_port(0, 1, 1, 4'hF, BASE + 32'(i * 4), $urandom);
            advance();
        end
        req = 2'b00;
        advance();
        for (int c = 0; c < 400; c++) begin
            predict();
            #1;
            n_checks++;
            if (gnt !== e_gnt || mem_en !== e_in) begin
                n_fail++;
                $display("FAIL rnd_gnt[%0d] got=%b/%b exp=%b/%b", c, gnt, mem_en, e_gnt, e_in);
            end
            if (e_in) begin
                n_checks++;
                if ({mem_we, mem_be, mem_addr, mem_wdata} !==
                    {we[e_win], be[e_win], 12'(widx(addr[e_win])), wdata[e_win]}) begin
                    n_fail++;
                    $display("FAIL rnd_mem[%0d] got=%h exp=%h", c,
                             {mem_we, mem_be, mem_addr, mem_wdata},
                             {we[e_win], be[e_win], 12'(widx(addr[e_win])), wdata[e_win]});
                end
            end else begin
                n_checks++;
                if ({mem_we, mem_be} !== 5'h0) begin
                    n_fail++;
                    $display("FAIL rnd_idle[%0d] got=%h exp=0", c, {mem_we, mem_be});
                end
            end
            n_checks++;
            if ({rvalid, err, rdata[0], rdata[1]} !==
                {x_rvalid(), x_err(), x_rdata(0), x_rdata(1)}) begin
                n_fail++;
                $display("FAIL rnd_resp[%0d] got=%h exp=%h", c,
                         {rvalid, err, rdata[0], rdata[1]},
                         {x_rvalid(), x_err(), x_rdata(0), x_rdata(1)});
            end
            advance();
            prev_win = e_win;
            for (int p = 0; p < 2; p++) begin
                if (prev_win == p || !req[p]) begin
                    idx = $urandom_range(0, 3);
                    set_port(p, $urandom_range(0, 99) < 70, $urandom_range(0, 2) == 0,
                             4'($urandom),
                             ($urandom_range(0, 9) == 0) ? 32'h0040_0000 + 32'(idx * 4)
                                                         : BASE + 32'(idx * 4),
                             $urandom);
                end
            end
        end
        req = 2'b00;
        advance();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_byte_enables();
        test_out_of_window();
        test_contention();
        test_fixed_priority();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
